snake_tile_renderer: RTL and testbench

SNAKE_TILE_RENDERER -- requirements
Module: snake_tile_renderer

---
 rtl/snake_pkg.sv | 48 ++++
 rtl/tile_map_ram.sv | 36 +++
 rtl/snake_tile_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_snake_tile_renderer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake tile renderer: game states, tile codes, build FSM states, colours.
// Pure definitions; no logic, no latency.
package snake_pkg;

  localparam int CELL_W = 2;

  typedef enum logic [1:0] {
    GS_RUNNING = 2'b00,
    GS_DIE     = 2'b01,
    GS_INITIAL = 2'b10,
    GS_RSVD    = 2'b11
  } game_state_e;

  typedef enum logic [CELL_W-1:0] {
    CELL_NONE = 2'b00,
    CELL_FOOD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_HEAD = 2'b11
  } cell_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FOOD,
    ST_FILL,
    ST_SWAP
  } build_state_e;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_FOOD   = 12'hfff;
  localparam logic [11:0] RGB_BODY   = 12'hf00;
  localparam logic [11:0] RGB_HEAD   = 12'hff0;
  localparam logic [11:0] RGB_INIT   = 12'h888;
  localparam logic [11:0] RGB_BORDER = 12'h444;

  // Frame-counter bit that selects the lit/dark half of the death blink.
  localparam int BLINK_BIT = 4;

  function automatic logic [11:0] cell_rgb(input cell_e c);
    case (c)
      CELL_FOOD: return RGB_FOOD;
      CELL_BODY: return RGB_BODY;
      CELL_HEAD: return RGB_HEAD;
      default:   return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Double-buffered tile map: write port (with old-value lookup) on the back bank, read port on the front bank.
// Read data registered, 1 cycle; writes land at the clock edge; no backpressure.
module tile_map_ram
  import snake_pkg::*;
#(
  parameter int DEPTH = 768,
  parameter int AW    = 10
) (
  input  logic              clk_i,
  input  logic              front_sel_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [CELL_W-1:0] wr_dat_i,
  output logic [CELL_W-1:0] wr_old_o,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [CELL_W-1:0] rd_dat_o
);

  logic [CELL_W-1:0] mem_q [2][DEPTH];
  logic [CELL_W-1:0] rd_dat_q;
  logic              back_sel;

  assign back_sel = ~front_sel_i;

  // Collision detection needs what is already in the back bank at the write address.
  assign wr_old_o = mem_q[back_sel][wr_addr_i];
  assign rd_dat_o = rd_dat_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[back_sel][wr_addr_i] <= wr_dat_i;
    end
    rd_dat_q <= mem_q[front_sel_i][rd_addr_i];
  end

endmodule

// File: rtl/snake_tile_renderer.sv
// Builds a tile map of the snake/food per frame into a back buffer and renders pixels from the front buffer.
// Pixel path fixed latency 2; build takes cells+1+L+1 cycles, frame_start during a build is dropped (frame_overrun).
module snake_tile_renderer
  import snake_pkg::*;
#(
  parameter int CELL_PX = 20,
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 64,
  parameter int COORD_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [MAX_LEN*COORD_W-1:0]   snake_x_flat,
  input  logic [MAX_LEN*COORD_W-1:0]   snake_y_flat,
  input  logic [$clog2(MAX_LEN+1)-1:0] snake_length,
  input  logic [COORD_W-1:0]           food_x,
  input  logic [COORD_W-1:0]           food_y,
  input  logic [1:0]                   game_state,
  input  logic [9:0]                   pix_x,
  input  logic [8:0]                   pix_y,
  input  logic                         pix_valid,
  output logic [11:0]                  pix_rgb,
  output logic                         pix_rgb_valid,
  output logic                         build_busy,
  output logic                         self_hit,
  output logic                         frame_overrun
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  function automatic logic in_grid(input int x, input int y);
    return (x < GRID_W) && (y < GRID_H);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input int x, input int y);
    return AW'(y * GRID_W + x);
  endfunction

  build_state_e               state_q, state_d;
  logic [AW-1:0]              clr_cnt_q;
  logic [IW-1:0]              seg_idx_q;
  logic [LW-1:0]              len_q;
  logic [MAX_LEN*COORD_W-1:0] snap_x_q, snap_y_q;
  logic [COORD_W-1:0]         food_x_q, food_y_q;
  logic                       coll_q, self_hit_q, front_sel_q, front_valid_q, overrun_q;
  logic [BLINK_BIT:0]         frame_cnt_q;

  logic [COORD_W-1:0]         seg_x, seg_y;
  logic                       seg_ok, food_ok;
  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  cell_e                      wr_dat;
  logic [CELL_W-1:0]          wr_old;

  assign seg_x   = snap_x_q[int'(seg_idx_q)*COORD_W +: COORD_W];
  assign seg_y   = snap_y_q[int'(seg_idx_q)*COORD_W +: COORD_W];
  assign seg_ok  = in_grid(int'(seg_x), int'(seg_y));
  assign food_ok = in_grid(int'(food_x_q), int'(food_y_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_cnt_q == AW'(CELLS - 1)) state_d = ST_FOOD;
      ST_FOOD:  state_d = (len_q == '0) ? ST_SWAP : ST_FILL;
      ST_FILL:  if (seg_idx_q == '0) state_d = ST_SWAP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_dat  = CELL_NONE;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q;
      end
      ST_FOOD: begin
        wr_en   = food_ok;
        wr_addr = food_ok ? cell_addr(int'(food_x_q), int'(food_y_q)) : '0;
        wr_dat  = CELL_FOOD;
      end
      ST_FILL: begin
        wr_en   = seg_ok;
        wr_addr = seg_ok ? cell_addr(int'(seg_x), int'(seg_y)) : '0;
        if (seg_idx_q == '0) wr_dat = CELL_HEAD;
        else                 wr_dat = CELL_BODY;
      end
      default: ;
    endcase
  end

  assign build_busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && frame_start) begin
      snap_x_q <= snake_x_flat;
      snap_y_q <= snake_y_flat;
      food_x_q <= food_x;
      food_y_q <= food_y;
      len_q    <= (snake_length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : snake_length;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q     <= '0;
      seg_idx_q     <= '0;
      coll_q        <= 1'b0;
      self_hit_q    <= 1'b0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      overrun_q <= frame_start && (state_q != ST_IDLE);
      if (frame_start) frame_cnt_q <= frame_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: if (frame_start) begin
          clr_cnt_q <= '0;
          coll_q    <= 1'b0;
        end
        ST_CLEAR: clr_cnt_q <= clr_cnt_q + 1'b1;
        ST_FOOD:  seg_idx_q <= IW'(len_q - 1'b1);
        ST_FILL: begin
          // Segment landing on an already-written segment; the later write still overwrites.
          if (wr_en && (wr_old == CELL_BODY || wr_old == CELL_HEAD)) coll_q <= 1'b1;
          seg_idx_q <= seg_idx_q - 1'b1;
        end
        ST_SWAP: begin
          front_sel_q   <= ~front_sel_q;
          front_valid_q <= 1'b1;
          self_hit_q    <= coll_q;
        end
        default: ;
      endcase
    end
  end

  assign self_hit      = self_hit_q;
  assign frame_overrun = overrun_q;

  int                px_cx, px_cy;
  logic              px_in;
  logic [AW-1:0]     rd_addr;
  logic [CELL_W-1:0] rd_dat;

  always_comb begin
    px_cx   = int'(pix_x) / CELL_PX;
    px_cy   = int'(pix_y) / CELL_PX;
    px_in   = in_grid(px_cx, px_cy);
    rd_addr = px_in ? cell_addr(px_cx, px_cy) : '0;
  end

  tile_map_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_map (
    .clk_i       (clk),
    .front_sel_i (front_sel_q),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_dat_i    (wr_dat),
    .wr_old_o    (wr_old),
    .rd_addr_i   (rd_addr),
    .rd_dat_o    (rd_dat)
  );

  logic        p1_vld_q, p1_in_q, p1_fv_q, p1_blink_q;
  logic [1:0]  p1_gs_q;
  logic [11:0] pix_rgb_q, rgb_d;
  logic        pix_rgb_vld_q;
  cell_e       p2_cell;

  always_comb begin
    p2_cell = p1_fv_q ? cell_e'(rd_dat) : CELL_NONE;
    rgb_d   = RGB_BLACK;
    if (p1_vld_q) begin
      case (p1_gs_q)
        GS_INITIAL: rgb_d = RGB_INIT;
        GS_RUNNING: rgb_d = p1_in_q ? cell_rgb(p2_cell) : RGB_BORDER;
        GS_DIE: begin
          if (!p1_in_q)                                         rgb_d = RGB_BORDER;
          else if (p2_cell == CELL_BODY || p2_cell == CELL_HEAD) rgb_d = p1_blink_q ? RGB_BLACK : RGB_BODY;
          else                                                  rgb_d = cell_rgb(p2_cell);
        end
        default: rgb_d = RGB_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld_q      <= 1'b0;
      p1_in_q       <= 1'b0;
      p1_fv_q       <= 1'b0;
      p1_blink_q    <= 1'b0;
      p1_gs_q       <= '0;
      pix_rgb_q     <= '0;
      pix_rgb_vld_q <= 1'b0;
    end else begin
      p1_vld_q      <= pix_valid;
      p1_in_q       <= px_in;
      p1_fv_q       <= front_valid_q;
      p1_blink_q    <= frame_cnt_q[BLINK_BIT];
      p1_gs_q       <= game_state;
      pix_rgb_q     <= rgb_d;
      pix_rgb_vld_q <= p1_vld_q;
    end
  end

  assign pix_rgb       = pix_rgb_q;
  assign pix_rgb_valid = pix_rgb_vld_q;

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Self-checking bench for snake_tile_renderer: build timing, map contents via pixels, collision, reset, blink.
// Pixel expectations queued at drive time and compared when the 2-cycle output appears.
module tb_snake_tile_renderer;

  localparam int MAX_LEN = 64;
  localparam int COORD_W = 5;
  localparam int LW      = 7;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       frame_start;
  logic [MAX_LEN*COORD_W-1:0] snake_x_flat, snake_y_flat;
  logic [LW-1:0]              snake_length;
  logic [COORD_W-1:0]         food_x, food_y;
  logic [1:0]                 game_state;
  logic [9:0]                 pix_x;
  logic [8:0]                 pix_y;
  logic                       pix_valid;
  logic [11:0]                pix_rgb;
  logic                       pix_rgb_valid, build_busy, self_hit, frame_overrun;

  always #5 clk = ~clk;

  snake_tile_renderer dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .snake_x_flat  (snake_x_flat),
    .snake_y_flat  (snake_y_flat),
    .snake_length  (snake_length),
    .food_x        (food_x),
    .food_y        (food_y),
    .game_state    (game_state),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_valid     (pix_valid),
    .pix_rgb       (pix_rgb),
    .pix_rgb_valid (pix_rgb_valid),
    .build_busy    (build_busy),
    .self_hit      (self_hit),
    .frame_overrun (frame_overrun)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int fcnt   = 0;

  typedef struct {
    int          due;
    logic        vld;
    logic [11:0] rgb;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  exp_t  mon_e;
  string mon_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      mon_t = sb_tag.pop_front();
      chk({mon_t, "_vld"}, 32'(pix_rgb_valid), 32'(mon_e.vld));
      chk({mon_t, "_rgb"}, 32'(pix_rgb), 32'(mon_e.rgb));
    end
  end

  task automatic probe(input logic [1:0] gs, input int x, input int y, input logic v,
                       input logic [11:0] rgb, input string tag);
    exp_t e;
    @(negedge clk);
    game_state = gs;
    pix_x      = 10'(x);
    pix_y      = 9'(y);
    pix_valid  = v;
    e.due = cyc + 2;
    e.vld = v;
    e.rgb = v ? rgb : 12'h000;
    sb.push_back(e);
    sb_tag.push_back(tag);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_seg(input int i, input int x, input int y);
    snake_x_flat[i*COORD_W +: COORD_W] = COORD_W'(x);
    snake_y_flat[i*COORD_W +: COORD_W] = COORD_W'(y);
  endtask

  // Pulse frame_start and measure how long build_busy stays high; optionally
  // fire a second frame_start ovr_at cycles into the build.
  task automatic run_build(input string tag, input int exp_cyc, input int ovr_at);
    int n;
    int ovr;
    @(negedge clk);
    frame_start = 1'b1;
    fcnt++;
    @(negedge clk);
    frame_start = 1'b0;
    n   = 0;
    ovr = 0;
    while (build_busy && n < 2000) begin
      if (frame_overrun) ovr++;
      n++;
      frame_start = (n == ovr_at);
      if (n == ovr_at) fcnt++;
      @(negedge clk);
    end
    frame_start = 1'b0;
    if (frame_overrun) ovr++;
    chk({tag, "_busy_cycles"}, n, exp_cyc);
    chk({tag, "_overruns"}, ovr, (ovr_at > 0) ? 1 : 0);
  endtask

  task automatic load_collision_snake();
    set_seg(0, 4, 5);
    set_seg(1, 5, 5);
    set_seg(2, 4, 5);
    set_seg(3, 7, 30);
    snake_length = 7'd4;
    food_x = 5'd10;
    food_y = 5'd10;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    frame_start  = 1'b0;
    snake_x_flat = '0;
    snake_y_flat = '0;
    snake_length = '0;
    food_x       = '0;
    food_y       = '0;
    game_state   = 2'b10;
    pix_x        = '0;
    pix_y        = '0;
    pix_valid    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(build_busy), 0);
    chk("rst_self_hit", 32'(self_hit), 0);
    chk("rst_overrun", 32'(frame_overrun), 0);
    chk("rst_rgb_vld", 32'(pix_rgb_valid), 0);
    chk("rst_rgb", 32'(pix_rgb), 0);
    rst  = 1'b0;
    fcnt = 0;

    probe(2'b10, 100, 100, 1'b1, 12'h888, "init_px");
    probe(2'b10, 100, 100, 1'b0, 12'h000, "no_valid");
    probe(2'b00, 110, 110, 1'b1, 12'h000, "no_front");
    probe(2'b00, 650, 100, 1'b1, 12'h444, "border_pre");

    set_seg(0, 5, 5);
    set_seg(1, 4, 5);
    set_seg(2, 3, 5);
    snake_length = 7'd3;
    food_x = 5'd10;
    food_y = 5'd10;
    run_build("b1", 773, 0);
    chk("b1_self_hit", 32'(self_hit), 0);
    probe(2'b00, 110, 110, 1'b1, 12'hff0, "b1_head");
    probe(2'b00,  90, 110, 1'b1, 12'hf00, "b1_body");
    probe(2'b00,  70, 110, 1'b1, 12'hf00, "b1_tail");
    probe(2'b00, 210, 210, 1'b1, 12'hfff, "b1_food");
    probe(2'b00, 300, 300, 1'b1, 12'h000, "b1_empty");
    probe(2'b00, 639, 479, 1'b1, 12'h000, "b1_last_cell");
    probe(2'b00, 640,   0, 1'b1, 12'h444, "b1_right_edge");
    probe(2'b00,   0, 480, 1'b1, 12'h444, "b1_bottom_edge");
    probe(2'b11, 110, 110, 1'b1, 12'h000, "b1_gs11");
    probe(2'b10, 650, 100, 1'b1, 12'h888, "b1_init_border");

    load_collision_snake();
    run_build("b2", 774, 10);
    chk("b2_self_hit", 32'(self_hit), 1);
    probe(2'b00,  90, 110, 1'b1, 12'hff0, "b2_head_wins");
    probe(2'b00, 110, 110, 1'b1, 12'hf00, "b2_body");
    probe(2'b00, 150, 130, 1'b1, 12'h000, "b2_dropped_seg");
    probe(2'b00, 210, 210, 1'b1, 12'hfff, "b2_food");

    for (int i = 0; i < MAX_LEN; i++) set_seg(i, i % 32, 10 + i / 32);
    snake_length = 7'd80;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (780) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    fcnt = 0;
    chk("fillrst_busy", 32'(build_busy), 0);
    chk("fillrst_self_hit", 32'(self_hit), 0);
    probe(2'b00, 110, 110, 1'b1, 12'h000, "fillrst_old_body");
    probe(2'b00,  90, 110, 1'b1, 12'h000, "fillrst_old_head");
    probe(2'b00, 110, 210, 1'b1, 12'h000, "fillrst_new_body");

    load_collision_snake();
    run_build("b3", 774, 0);
    chk("b3_self_hit", 32'(self_hit), 1);

    snake_length = 7'd0;
    food_x = 5'd2;
    food_y = 5'd3;
    run_build("len0", 770, 0);
    chk("len0_self_hit", 32'(self_hit), 0);
    probe(2'b00,  50,  70, 1'b1, 12'hfff, "len0_food");
    probe(2'b00,  90, 110, 1'b1, 12'h000, "len0_no_head");

    for (int i = 0; i < MAX_LEN; i++) set_seg(i, i % 32, 10 + i / 32);
    snake_length = 7'd80;
    run_build("clamp", 834, 0);
    chk("clamp_self_hit", 32'(self_hit), 0);
    probe(2'b00,   0, 210, 1'b1, 12'hff0, "clamp_head");
    probe(2'b00, 110, 210, 1'b1, 12'hf00, "clamp_body");
    probe(2'b00, 625, 230, 1'b1, 12'hf00, "clamp_seg63");

    probe(2'b01, 650, 100, 1'b1, 12'h444, "die_border");
    for (int k = 0; k < 32; k++) begin
      run_build("die", 834, 0);
      probe(2'b01, 110, 210, 1'b1, (((fcnt % 32) / 16) == 0) ? 12'hf00 : 12'h000, "die_body");
    end

    repeat (4) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
